// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - launcher state encodings and default constants for the UART TX FIFO
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE       = 2'd0,
        TX_LAUNCH     = 2'd1,
        TX_WAIT_START = 2'd2,
        TX_WAIT_DONE  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_DEPTH_LOG2    = 4;
    localparam int DEFAULT_LOW_WATERMARK = 4;
    localparam int DEFAULT_START_TIMEOUT = 3;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - generic synchronous 8-bit FIFO with push/pop/flush and occupancy count
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [7:0]            head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Guard against overrun/underrun locally so the FIFO is safe on its own.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next pointer/count; flush collapses everything back to empty in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO plus launcher feeding the UART core; UART_TX_FIFO_LEVEL_EN adds level/low_water
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
    parameter int LOW_WATERMARK = DEFAULT_LOW_WATERMARK,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_stb,
    input  logic [7:0]          wr_data,
    input  logic                flush,
    input  logic                clear_overflow,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                busy,
    output logic                transmit,
    output logic [7:0]          tx_byte,
    input  logic                is_transmitting
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level,
    output logic                low_water
`endif
);

    localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    tx_state_e           state_q, state_d;
    logic [TMO_W-1:0]    timer_q, timer_d;
    logic                transmit_q, transmit_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                overflow_q, overflow_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                push;
    logic                pop;
    logic                ovf_set;

    // A byte is accepted only when there is room and no flush this cycle.
    assign push    = wr_stb && !fifo_full && !flush;
    assign ovf_set = wr_stb && fifo_full && !flush;

    uart_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .flush     (flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = (fifo_count != '0) || (state_q != TX_IDLE);

    // Launcher next state: pop and launch from IDLE, then track the core's busy status.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop        = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !is_transmitting) begin
                    state_d    = TX_LAUNCH;
                    tx_byte_d  = fifo_head;
                    pop        = 1'b1;
                    transmit_d = 1'b1;
                end
            end
            TX_LAUNCH: begin
                state_d = TX_WAIT_START;
                timer_d = '0;
            end
            TX_WAIT_START: begin
                // A core that never starts (e.g. reset by a divider change) must not wedge us.
                if (is_transmitting) begin
                    state_d = TX_WAIT_DONE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = TX_IDLE;
                end else begin
                    timer_d = timer_q + TMO_ONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!is_transmitting) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Sticky overflow; a new drop in the same cycle beats the clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Launcher and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= TX_IDLE;
            timer_q    <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    localparam logic [DEPTH_LOG2:0] LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] LVL_LOW = (DEPTH_LOG2+1)'(LOW_WATERMARK);

    logic [DEPTH_LOG2:0] level_nxt;
    logic                low_water_q, low_water_d;

    assign level     = fifo_count;
    assign low_water = low_water_q;

    // Next occupancy, so the registered low_water lines up with the count.
    always_comb begin
        level_nxt = fifo_count;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = fifo_count + LVL_ONE;
        end else if (pop && !push) begin
            level_nxt = fifo_count - LVL_ONE;
        end
        low_water_d = (level_nxt <= LVL_LOW);
    end

    // Registered watermark flag for interrupt use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            low_water_q <= 1'b1;
        end else begin
            low_water_q <= low_water_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo; level checks active when UART_TX_FIFO_LEVEL_EN is defined
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       flush;
    logic       clear_overflow;
    logic       full, empty, overflow, busy, transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
    logic       low_water;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural UART core: goes busy for core_len cycles after each launch.
    logic core_force = 1'b0;
    logic core_mute  = 1'b0;
    int   core_len   = 10;
    int   core_cnt   = 0;
    logic prev_tx    = 1'b0;
    logic prev_it    = 1'b0;

    logic [7:0] sent[$];
    logic [7:0] mq[$];
    logic       movf;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       fl;
        logic       clr;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_busy;
        int         e_level;
    } vec_t;

    uart_tx_fifo dut (
        .clk             (clk),
        .rst             (rst),
        .wr_stb          (wr_stb),
        .wr_data         (wr_data),
        .flush           (flush),
        .clear_overflow  (clear_overflow),
        .full            (full),
        .empty           (empty),
        .overflow        (overflow),
        .busy            (busy),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level           (level),
        .low_water       (low_water)
`endif
    );

    assign is_transmitting = core_force || (core_cnt != 0);

    always @(posedge clk) begin
        if (!rst) begin
            core_cnt <= 0;
            prev_tx  <= 1'b0;
            prev_it  <= 1'b0;
        end else begin
            if (transmit) begin
                sent.push_back(tx_byte);
                n_cmp++;
                if (prev_tx || prev_it || is_transmitting) begin
                    n_fail++;
                    $display("FAIL launch_protocol: prev_transmit=%0b prev_is_tx=%0b is_tx=%0b, required all 0",
                             prev_tx, prev_it, is_transmitting);
                end
                if (!core_mute) core_cnt <= core_len;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
            end
            prev_tx <= transmit;
            prev_it <= is_transmitting;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic f, input logic c);
        wr_stb         = w;
        wr_data        = d;
        flush          = f;
        clear_overflow = c;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        core_force = 1'b0;
        core_mute  = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        sent.delete();
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && busy; i++) step();
        chk(name, busy, 0);
    endtask

    task automatic wait_tx(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && !transmit; i++) step();
        chk(name, transmit, 1);
    endtask

    // One cycle against the queue model: pops are whatever the DUT launched, checked for order.
    task automatic model_cycle(input logic w, input logic [7:0] d, input logic f, input logic c);
        logic       pre_full;
        logic [7:0] exp_b;
        pre_full = (mq.size() == 16);
        drive(w, d, f, c);
        step();
        if (transmit) begin
            chk("rnd_launch_nonempty", (mq.size() != 0), 1);
            if (mq.size() != 0) begin
                exp_b = mq.pop_front();
                chk("rnd_tx_byte", tx_byte, exp_b);
            end
        end
        if (f) mq.delete();
        else if (w && !pre_full) mq.push_back(d);
        if (w && pre_full && !f) movf = 1'b1;
        else if (c) movf = 1'b0;
        chk("rnd_full", full, (mq.size() == 16));
        chk("rnd_empty", empty, (mq.size() == 0));
        chk("rnd_overflow", overflow, movf);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rnd_level", level, mq.size());
        chk("rnd_low_water", low_water, (mq.size() <= 4));
`endif
    endtask

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic f, input logic c,
                                input logic ef, input logic ee, input logic eo, input logic eb,
                                input int el);
        vec_t v;
        v.wr = w; v.data = d; v.fl = f; v.clr = c;
        v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_busy = eb; v.e_level = el;
        return v;
    endfunction

    initial begin
        vec_t tbl[24];
        int   gap;

        // Table: core held busy, so nothing launches; fill, overflow, clear, flush priority.
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, (i == 15), 1'b0, 1'b0, 1'b1, i + 1);
        tbl[16] = mk(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16);
        tbl[18] = mk(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16);
        tbl[20] = mk(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        tbl[21] = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[22] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_tx_byte", tx_byte, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rst_level", level, 0);
        chk("rst_low_water", low_water, 1);
`endif
        rst = 1'b1;
        sent.delete();

        core_force = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].wr, tbl[i].data, tbl[i].fl, tbl[i].clr);
            step();
            chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].e_ovf);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
`ifdef UART_TX_FIFO_LEVEL_EN
            chk($sformatf("vec%0d_level", i), level, tbl[i].e_level);
            chk($sformatf("vec%0d_low_water", i), low_water, (tbl[i].e_level <= 4));
`endif
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        core_force = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("vec_no_launch_after_flush", sent.size(), 0);

        // Single byte: empty falls in N+1, transmit in N+2, busy clears after the core finishes.
        do_reset();
        core_len = 20;
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        chk("single_empty_n1", empty, 0);
        chk("single_transmit_n1", transmit, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("single_transmit_n2", transmit, 1);
        chk("single_tx_byte", tx_byte, 8'h55);
        step();
        chk("single_transmit_n3", transmit, 0);
        chk("single_tx_byte_held", tx_byte, 8'h55);
        chk("single_busy_during", busy, 1);
        wait_idle(100, "single_busy_drop");
        chk("single_core_idle_at_drop", is_transmitting, 0);
        chk("single_count", sent.size(), 1);

        // Burst of five behind a slow core.
        sent.delete();
        core_len = 80;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        wait_idle(1000, "burst_drain");
        chk("burst_count", sent.size(), 5);
        for (int i = 0; i < 5 && i < sent.size(); i++)
            chk($sformatf("burst_byte%0d", i), sent[i], i + 1);

        // Overflow: seventeenth byte dropped and never sent.
        do_reset();
        core_force = 1'b1;
        core_len   = 4;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            step();
            if (i == 15) begin
                chk("ovf_full_at_16", full, 1);
                chk("ovf_clear_at_16", overflow, 0);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_full_at_17", full, 1);
        chk("ovf_set_at_17", overflow, 1);
        core_force = 1'b0;
        wait_idle(600, "ovf_drain");
        chk("ovf_sent_count", sent.size(), 16);
        if (sent.size() == 16) begin
            chk("ovf_first_byte", sent[0], 8'h20);
            chk("ovf_last_byte", sent[15], 8'h2F);
        end
        chk("ovf_sticky", overflow, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_cleared", overflow, 0);

        // Flush with a concurrent write while a launched byte is in flight.
        do_reset();
        core_len = 40;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h91 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_empty", empty, 1);
        chk("flush_no_overflow", overflow, 0);
        chk("flush_launch_continues", busy, 1);
        wait_idle(200, "flush_drain");
        chk("flush_sent_count", sent.size(), 1);
        if (sent.size() != 0) chk("flush_sent_byte", sent[0], 8'h91);

        // Start timeout: core never raises is_transmitting.
        do_reset();
        core_mute = 1'b1;
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h62, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        wait_tx(10, "timeout_first_launch");
        gap = 0;
        do begin
            step();
            gap++;
        end while (!transmit && gap < 20);
        chk("timeout_launch_gap", gap, 5);
        wait_idle(30, "timeout_idle");
        chk("timeout_sent_count", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("timeout_byte0", sent[0], 8'h61);
            chk("timeout_byte1", sent[1], 8'h62);
        end
        core_mute = 1'b0;

`ifdef UART_TX_FIFO_LEVEL_EN
        // Level and watermark around the threshold.
        do_reset();
        core_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lvl_level5", level, 5);
        chk("lvl_low_water5", low_water, 0);
        core_force = 1'b0;
        wait_tx(10, "lvl_launch");
        chk("lvl_level4", level, 4);
        chk("lvl_low_water4", low_water, 1);
`endif

        // Reset asserted on a transmit pulse with overflow set.
        do_reset();
        core_force = 1'b1;
        core_len   = 30;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        core_force = 1'b0;
        wait_tx(10, "rstmid_first_launch");
        step();
        wait_tx(100, "rstmid_second_launch");
        rst = 1'b0;
        step();
        chk("rstmid_transmit", transmit, 0);
        chk("rstmid_tx_byte", tx_byte, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_full", full, 0);
        chk("rstmid_overflow", overflow, 0);
        chk("rstmid_busy", busy, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rstmid_level", level, 0);
        chk("rstmid_low_water", low_water, 1);
`endif
        rst = 1'b1;

        // Randomized traffic against the queue model, then drain.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            core_len = int'($urandom_range(1, 12));
            model_cycle(1'($urandom_range(0, 1)), 8'($urandom),
                        ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 1500 && (busy || mq.size() != 0); i++)
            model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rnd_drain_busy", busy, 0);
        chk("rnd_drain_model_empty", mq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
